// File: rtl/acc_pkg.sv
// -----------------------------------------------------------------------------
// acc_pkg
// Shared definitions for the accumulator controller and its sibling ALU:
//   op_e     - 3-bit instruction opcodes (110/111 are illegal and not listed)
//   ALU_*    - ALU select encodings, shared with the ALU owner
//   state_e  - controller FSM states
//   alu_sel_for_op - select driven during EXEC for a registered opcode
// -----------------------------------------------------------------------------
package acc_pkg;

    typedef enum logic [2:0] {
        OP_NOP   = 3'b000,
        OP_CLR   = 3'b001,
        OP_ADD   = 3'b010,
        OP_SUB   = 3'b011,
        OP_LOAD  = 3'b100,
        OP_STORE = 3'b101
    } op_e;

    localparam logic [1:0] ALU_CLR  = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_SUB  = 2'b10;
    localparam logic [1:0] ALU_PASS = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        EXEC  = 2'b01,
        LOAD2 = 2'b10,
        OUT   = 2'b11
    } state_e;

    // LOAD clears first, then adds the immediate in LOAD2.
    function automatic logic [1:0] alu_sel_for_op(input logic [2:0] op);
        logic [1:0] sel;
        case (op)
            OP_CLR:  sel = ALU_CLR;
            OP_ADD:  sel = ALU_ADD;
            OP_SUB:  sel = ALU_SUB;
            OP_LOAD: sel = ALU_CLR;
            default: sel = ALU_PASS;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/acc_ctrl.sv
// -----------------------------------------------------------------------------
// acc_ctrl
// Accumulator controller feeding a sibling 16-bit combinational ALU.
// Ports:
//   clk, rst_n                       - clock, async active-low reset
//   instr_valid/ready, instr_op/imm  - instruction handshake
//   alu_a, alu_b, alu_sel, alu_out   - ALU operands/select and result
//   out_valid/ready, out_data        - STORE result handshake
//   acc_q, acc_zero                  - accumulator and zero flag
//   busy, err, instr_count           - status: not idle, sticky illegal op,
//                                      retired-instruction counter (wraps)
// -----------------------------------------------------------------------------
module acc_ctrl
    import acc_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [2:0]       instr_op,
    input  logic [WIDTH-1:0] instr_imm,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [WIDTH-1:0] acc_q,
    output logic             acc_zero,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] instr_count
);

    state_e           state_r;
    logic [2:0]       op_r;
    logic [WIDTH-1:0] imm_r;
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] out_data_r;
    logic             out_valid_r;
    logic             err_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_inc_s;

    assign cnt_inc_s   = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};

    // rst_n gating keeps instr_ready low throughout reset.
    assign instr_ready = rst_n & (state_r == IDLE);
    assign alu_a       = acc_r;
    assign acc_q       = acc_r;
    assign acc_zero    = (acc_r == {WIDTH{1'b0}});
    assign busy        = (state_r != IDLE);
    assign err         = err_r;
    assign out_valid   = out_valid_r;
    assign out_data    = out_data_r;
    assign instr_count = cnt_r;

    // ALU operand/select decode from registered state and op only.
    always_comb begin
        alu_sel = ALU_PASS;
        alu_b   = {WIDTH{1'b0}};
        case (state_r)
            IDLE: begin
                alu_sel = ALU_PASS;
                alu_b   = {WIDTH{1'b0}};
            end
            EXEC: begin
                alu_sel = alu_sel_for_op(op_r);
                alu_b   = imm_r;
            end
            LOAD2: begin
                alu_sel = ALU_ADD;
                alu_b   = imm_r;
            end
            OUT: begin
                alu_sel = ALU_PASS;
                alu_b   = {WIDTH{1'b0}};
            end
            default: begin
                alu_sel = ALU_PASS;
                alu_b   = {WIDTH{1'b0}};
            end
        endcase
    end

    // Controller FSM with accumulator, output and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            op_r        <= 3'b000;
            imm_r       <= {WIDTH{1'b0}};
            acc_r       <= {WIDTH{1'b0}};
            out_data_r  <= {WIDTH{1'b0}};
            out_valid_r <= 1'b0;
            err_r       <= 1'b0;
            cnt_r       <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (instr_valid) begin
                        op_r    <= instr_op;
                        imm_r   <= instr_imm;
                        state_r <= EXEC;
                    end
                end
                EXEC: begin
                    case (op_r)
                        OP_CLR, OP_ADD, OP_SUB: begin
                            acc_r   <= alu_out;
                            cnt_r   <= cnt_inc_s;
                            state_r <= IDLE;
                        end
                        OP_LOAD: begin
                            // Clear now; the immediate is added in LOAD2.
                            acc_r   <= alu_out;
                            state_r <= LOAD2;
                        end
                        OP_STORE: begin
                            out_data_r  <= acc_r;
                            out_valid_r <= 1'b1;
                            state_r     <= OUT;
                        end
                        OP_NOP: begin
                            cnt_r   <= cnt_inc_s;
                            state_r <= IDLE;
                        end
                        default: begin
                            err_r   <= 1'b1;
                            cnt_r   <= cnt_inc_s;
                            state_r <= IDLE;
                        end
                    endcase
                end
                LOAD2: begin
                    acc_r   <= alu_out;
                    cnt_r   <= cnt_inc_s;
                    state_r <= IDLE;
                end
                OUT: begin
                    // Result stays offered until the consumer takes it.
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        cnt_r       <= cnt_inc_s;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/acc_ctrl.md
Name: acc_ctrl

Overview:
Accumulator controller that sits directly upstream of the 16-bit combinational ALU and consumes its result. It accepts instruction words over a valid/ready handshake and holds the accumulator register. It drives the ALU operands and select, latches the ALU result back into the accumulator, and emits STORE results over a second valid/ready handshake. The ALU is instantiated beside it at the parent level, not inside it.

Parameters:
WIDTH, 16, datapath width; must equal ALU width.
CNT_W, 16, width of retired-instruction counter.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
instr_valid  in  1  instruction offered
instr_ready  out  1  controller can accept instruction
instr_op  in  3  opcode: 000 NOP, 001 CLR, 010 ADD, 011 SUB, 100 LOAD, 101 STORE, 110/111 illegal
instr_imm  in  WIDTH  immediate operand
alu_a  out  WIDTH  ALU input A; always equals acc_q
alu_b  out  WIDTH  ALU input B
alu_sel  out  2  ALU select: 00 clear, 01 add, 10 sub, 11 pass A
alu_out  in  WIDTH  ALU result
out_valid  out  1  STORE result available
out_ready  in  1  downstream accepts result
out_data  out  WIDTH  stored accumulator value
acc_q  out  WIDTH  current accumulator
acc_zero  out  1  high when acc_q == 0
busy  out  1  high when state != IDLE
err  out  1  sticky illegal-opcode flag
instr_count  out  CNT_W  retired instructions, wraps mod 2^CNT_W

Behaviour:
- Reset (rst_n low, asynchronous):
  - State = IDLE.
  - acc_q, op/imm registers, out_data, out_valid, err and instr_count all 0.
  - instr_ready is forced 0 while rst_n is low.
- States: IDLE, EXEC, LOAD2, OUT.
- IDLE:
  - instr_ready=1, alu_sel=11, alu_b=0.
  - On instr_valid && instr_ready: capture instr_op and instr_imm into internal registers; next state EXEC.
- EXEC (instr_ready=0; alu_b=captured imm; alu_sel decoded from the registered op):
  - CLR: sel=00; acc_q<=alu_out; -> IDLE.
  - ADD: sel=01; acc_q<=alu_out; -> IDLE.
  - SUB: sel=10; acc_q<=alu_out; -> IDLE.
  - LOAD: sel=00; acc_q<=alu_out (i.e. 0); -> LOAD2.
  - STORE: sel=11; out_data<=acc_q; out_valid<=1; -> OUT.
  - NOP: sel=11; acc_q unchanged; -> IDLE.
  - Illegal: sel=11; acc_q unchanged; err<=1; -> IDLE.
- LOAD2: sel=01, alu_b=imm; acc_q<=alu_out (0+imm); -> IDLE.
- OUT:
  - out_valid=1; out_data held stable; sel=11.
  - On out_ready: out_valid<=0; -> IDLE.
  - out_valid never drops without a handshake.
- Retirement: instr_count increments by 1 on the transition back to IDLE. It increments once per instruction, including NOP, illegal, LOAD and STORE.
- Latency and throughput:
  - Accepted at edge n: CLR/ADD/SUB/NOP retire at edge n+1.
  - LOAD retires at edge n+2.
  - STORE: out_valid rises after edge n+1 and retires on the handshake edge.
  - Maximum throughput is one instruction per 2 cycles. instr_ready is never high in the same cycle as EXEC (no bypass).
- Arithmetic: all arithmetic is mod 2^WIDTH, wrapping through the ALU. There are no carry or overflow flags.
- acc_zero and alu_a are combinational from acc_q. alu_sel and alu_b are combinational from registered state and op only, so they are glitch-free with respect to the inputs.
- Asynchronous reset mid-operation (EXEC, LOAD2 or OUT): the in-flight instruction is discarded, out_valid drops immediately, and all registers return to their reset values.
- instr_* inputs are ignored whenever instr_ready=0.

Decomposition:
- Shared package acc_pkg, holding:
  - op_e enum for the 3-bit opcodes;
  - ALU select constants ALU_CLR=2'b00, ALU_ADD=2'b01, ALU_SUB=2'b10, ALU_PASS=2'b11;
  - state_e enum {IDLE, EXEC, LOAD2, OUT}.
- The ALU select constants are shared with the ALU's owner.
- No sub-module: the FSM and datapath live in one module. The ALU stays a sibling wired at the parent level.

Test Plan:
1. Hold rst_n low 3 cycles, then release -> acc_q=0, acc_zero=1, out_valid=0, instr_count=0, err=0; instr_ready=0 during reset and 1 afterwards.
2. LOAD imm=0x1234, then ADD imm=0x0001 -> acc_q=0x1234 two edges after the LOAD is accepted; acc_q=0x1235 one edge after the ADD is accepted; instr_count=2.
3. LOAD 0x0000; SUB 0x0001 -> acc_q=0xFFFF, acc_zero=0. Then ADD 0x0001 -> acc_q=0x0000, acc_zero=1.
4. With acc_q=0x1235: STORE with out_ready low for 5 cycles -> out_valid=1 and out_data=0x1235 stable, instr_ready=0, busy=1. Raise out_ready -> handshake completes, out_valid=0 next cycle, back to IDLE, instr_count +1.
5. Op 3'b110 with acc_q=0x00AA -> acc_q stays 0x00AA, err=1 and stays 1 through later legal ops, instr_count +1.
6. Assert rst_n low during LOAD2 of LOAD 0x5555 -> acc_q=0 immediately, state IDLE, instr_count=0. After release, acc_q stays 0 with no retired instruction.
